// File: rtl/rs_entry.sv
// Single reservation-station entry: holds one instruction,
// snoops two CDBs for operand wakeup, issues via valid/ready.
module rs_entry #(
  parameter int DATA_W = 114,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] disp_data,
  input  logic [TAG_W-1:0]  disp_entry_num,
  input  logic              disp_valid,
  output logic              empty,
  input  logic              cdb0_valid,
  input  logic [TAG_W-1:0]  cdb0_tag,
  input  logic [31:0]       cdb0_data,
  input  logic              cdb1_valid,
  input  logic [TAG_W-1:0]  cdb1_tag,
  input  logic [31:0]       cdb1_data,
  input  logic              flush,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [DATA_W-1:0] issue_data,
  output logic [TAG_W-1:0]  issue_rob_idx
);

  localparam int S1V = 5;
  localparam int S1  = 6;
  localparam int S2V = 38;
  localparam int S2  = 39;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT,
    S_READY
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [TAG_W-1:0]  rob_q, rob_d;
  logic [DATA_W-1:0] src, woke;
  logic              both;

  // Wakeup runs on the incoming word while empty so a
  // broadcast coinciding with dispatch is captured.
  always_comb begin
    src = (state_q == S_EMPTY) ? disp_data : word_q;
    woke = src;
    if (!src[S1V]) begin
      if (cdb0_valid && cdb0_tag == src[S1 +: TAG_W]) begin
        woke[S1 +: 32] = cdb0_data;
        woke[S1V]      = 1'b1;
      end else if (cdb1_valid && cdb1_tag == src[S1 +: TAG_W]) begin
        woke[S1 +: 32] = cdb1_data;
        woke[S1V]      = 1'b1;
      end
    end
    if (!src[S2V]) begin
      if (cdb0_valid && cdb0_tag == src[S2 +: TAG_W]) begin
        woke[S2 +: 32] = cdb0_data;
        woke[S2V]      = 1'b1;
      end else if (cdb1_valid && cdb1_tag == src[S2 +: TAG_W]) begin
        woke[S2 +: 32] = cdb1_data;
        woke[S2V]      = 1'b1;
      end
    end
    both = woke[S1V] & woke[S2V];
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rob_d   = rob_q;
    if (flush) begin
      state_d = S_EMPTY;
      word_d  = '0;
      rob_d   = '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (disp_valid) begin
            word_d  = woke;
            rob_d   = disp_entry_num;
            state_d = both ? S_READY : S_WAIT;
          end
        end
        S_WAIT: begin
          word_d = woke;
          if (both) state_d = S_READY;
        end
        S_READY: begin
          if (issue_ready) begin
            state_d = S_EMPTY;
            word_d  = '0;
            rob_d   = '0;
          end
        end
        default: begin
          state_d = S_EMPTY;
          word_d  = '0;
          rob_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      word_q  <= '0;
      rob_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rob_q   <= rob_d;
    end
  end

  assign empty         = (state_q == S_EMPTY);
  assign issue_valid   = (state_q == S_READY);
  assign issue_data    = word_q;
  assign issue_rob_idx = rob_q;

endmodule
